// File: rtl/exec_unit_pkg.sv
// Shared widths, opcodes and the single-cycle ALU evaluation used by the execute stage.
package exec_unit_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ovf;
  } alu_res_t;

  function automatic alu_res_t alu_eval(input logic [2:0] op,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    alu_res_t   r;
    logic [3:0] sh;
    r  = '0;
    sh = b[3:0];
    case (op)
      OP_ADD: begin
        r.data = a + b;
        r.ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (r.data[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        r.data = a - b;
        r.ovf  = (a[DATA_W-1] != b[DATA_W-1]) && (r.data[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  r.data = a & b;
      OP_OR:   r.data = a | b;
      OP_XOR:  r.data = a ^ b;
      OP_SHL:  r.data = a << sh;
      OP_SRA:  r.data = $signed(a) >>> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  // 17 bits so that |-32768| is representable
  function automatic logic [DATA_W:0] mag17(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] x;
    x = {v[DATA_W-1], v};
    return v[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction
endpackage

// File: rtl/exec_unit_if.sv
// Issue and writeback signals of the execute stage.
interface exec_unit_if;
  logic                             issue_valid;
  logic                             issue_ready;
  logic [2:0]                       issue_op;
  logic [exec_unit_pkg::ADDR_W-1:0] issue_dst;
  logic [exec_unit_pkg::DATA_W-1:0] opnd_a;
  logic [exec_unit_pkg::DATA_W-1:0] opnd_b;
  logic                             wb_we;
  logic [exec_unit_pkg::ADDR_W-1:0] wb_addr;
  logic [exec_unit_pkg::DATA_W-1:0] wb_data;
  logic                             wb_ovf;
  logic                             busy;

  modport master (
    output issue_valid, issue_op, issue_dst, opnd_a, opnd_b,
    input  issue_ready, wb_we, wb_addr, wb_data, wb_ovf, busy
  );

  modport slave (
    input  issue_valid, issue_op, issue_dst, opnd_a, opnd_b,
    output issue_ready, wb_we, wb_addr, wb_data, wb_ovf, busy
  );
endinterface

// File: rtl/exec_unit_mul_seq.sv
// Iterative 16-step shift-add magnitude multiplier. prod is the signed result of the
// step in progress, so it is final in the same cycle done is high.
module mul_seq
  import exec_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DATA_W:0] a_mag,
  input  logic [DATA_W:0] b_mag,
  input  logic            neg,
  output logic            done,
  output logic [31:0]     prod
);
  logic            active;
  logic [3:0]      count;
  logic [DATA_W:0] mcand;
  logic [DATA_W:0] mplier;
  logic            sign;
  logic [31:0]     acc;
  logic [31:0]     partial;
  logic [31:0]     acc_next;

  always_comb begin
    partial  = mplier[{1'b0, count}] ? (32'(mcand) << count) : 32'd0;
    acc_next = acc + partial;
    prod     = sign ? (~acc_next + 32'd1) : acc_next;
    done     = active && (count == 4'd15);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      sign   <= 1'b0;
      acc    <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      mcand  <= a_mag;
      mplier <= b_mag;
      sign   <= neg;
      acc    <= '0;
    end else if (active) begin
      acc   <= acc_next;
      count <= count + 4'd1;
      if (count == 4'd15) active <= 1'b0;
    end
  end
endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus a stalling 16-iteration MUL, with a registered
// writeback triple toward the register file.
module exec_unit
  import exec_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  exec_unit_if.slave  bus
);
  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state;
  logic              busy_q;
  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [31:0]       mul_prod;
  logic [ADDR_W-1:0] dst_q;
  logic              wb_we_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_ovf_q;
  alu_res_t          alu;

  assign accept    = bus.issue_valid && !busy_q;
  assign mul_start = accept && (bus.issue_op == OP_MUL);
  assign alu       = alu_eval(bus.issue_op, bus.opnd_a, bus.opnd_b);

  mul_seq u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a_mag (mag17(bus.opnd_a)),
    .b_mag (mag17(bus.opnd_b)),
    .neg   (bus.opnd_a[DATA_W-1] ^ bus.opnd_b[DATA_W-1]),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy_q    <= 1'b0;
      dst_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_ovf_q  <= 1'b0;
    end else begin
      wb_we_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (bus.issue_op == OP_MUL) begin
              state  <= S_MUL;
              busy_q <= 1'b1;
              dst_q  <= bus.issue_dst;
            end else begin
              wb_we_q   <= 1'b1;
              wb_addr_q <= bus.issue_dst;
              wb_data_q <= alu.data;
              wb_ovf_q  <= alu.ovf;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            wb_we_q   <= 1'b1;
            wb_addr_q <= dst_q;
            wb_data_q <= mul_prod[DATA_W-1:0];
            // fits in 16 signed bits only if bits 31..15 are all equal
            wb_ovf_q  <= !((&mul_prod[31:DATA_W-1]) || !(|mul_prod[31:DATA_W-1]));
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.issue_ready = !busy_q;
  assign bus.busy        = busy_q;
  assign bus.wb_we       = wb_we_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_ovf      = wb_ovf_q;
endmodule
